seq_detect_010: RTL and testbench

SEQ_DETECT_010 -- requirements
Module: seq_detect_010

---
 rtl/seq_detect_010.sv | 60 ++++++
 tb/tb_seq_detect_010.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/seq_detect_010.sv
// Overlapping "010" serial pattern detector: Moore FSM with a one-cycle detect flag and a
// 10-bit detection counter. Define SEQ_DETECT_010_SAT_EN for a saturating count (else it wraps).
module seq_detect_010 (
  input  logic       clk,
  input  logic       rst,
  input  logic       x,
  output logic       y,
  output logic [9:0] count
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StS0   = 2'b01,
    StS01  = 2'b10,
    StDet  = 2'b11
  } state_e;

  state_e     state_q, state_d;
  logic [9:0] count_q, count_d;

  always_comb begin
    state_d = StIdle;
    unique case (state_q)
      StIdle:  state_d = x ? StIdle : StS0;
      StS0:    state_d = x ? StS01  : StS0;
      StS01:   state_d = x ? StIdle : StDet;
      // The trailing 0 of a match is also the leading 0 of the next one.
      StDet:   state_d = x ? StS01  : StS0;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (state_d == StDet) begin
`ifdef SEQ_DETECT_010_SAT_EN
      if (count_q != 10'd1023) begin
        count_d = count_q + 10'd1;
      end
`else
      count_d = count_q + 10'd1;
`endif
    end
  end

  // Reset wins over a simultaneous match, so neither state nor count advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= 10'd0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign y     = (state_q == StDet);
  assign count = count_q;

endmodule

// File: tb/tb_seq_detect_010.sv
// Directed and random checks of seq_detect_010 against a sliding-window reference model.
module tb_seq_detect_010;

  logic       clk;
  logic       rst;
  logic       x;
  logic       y;
  logic [9:0] count;

  int n_cmp;
  int n_bad;

  // Reference model: last three samples since reset and the total number of matches.
  logic [2:0] hist;
  int         nsamp;
  int         nmatch;
  logic       exp_y;
  logic [9:0] exp_cnt;

  seq_detect_010 dut (
    .clk   (clk),
    .rst   (rst),
    .x     (x),
    .y     (y),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] count_of(input int n);
`ifdef SEQ_DETECT_010_SAT_EN
    return (n > 1023) ? 10'd1023 : 10'(n);
`else
    return 10'(n % 1024);
`endif
  endfunction

  task automatic check(input string tag, input logic [9:0] obs, input logic [9:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare shortly after it.
  task automatic step(input logic xv, input logic rv);
    x   = xv;
    rst = rv;
    @(posedge clk);
    if (rv) begin
      hist   = 3'b000;
      nsamp  = 0;
      nmatch = 0;
      exp_y  = 1'b0;
    end else begin
      hist  = {hist[1:0], xv};
      nsamp = nsamp + 1;
      exp_y = (nsamp >= 3) && (hist == 3'b010);
      if (exp_y) nmatch = nmatch + 1;
    end
    exp_cnt = count_of(nmatch);
    #1;
    check("y_model", {9'd0, y}, {9'd0, exp_y});
    check("count_model", count, exp_cnt);
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    hist   = 3'b000;
    nsamp  = 0;
    nmatch = 0;
    exp_y  = 1'b0;
    rst    = 1'b1;
    x      = 1'b0;

    // Reset with x unknown
    step(1'bx, 1'b1);
    step(1'b1, 1'b1);
    check("reset_y", {9'd0, y}, 10'd0);
    check("reset_count", count, 10'd0);

    // "010" then "10": two overlapping detections
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    check("pre_det_y", {9'd0, y}, 10'd0);
    step(1'b0, 1'b0);
    check("first_det_y", {9'd0, y}, 10'd1);
    check("first_det_count", count, 10'd1);
    step(1'b1, 1'b0);
    check("first_det_falls", {9'd0, y}, 10'd0);
    step(1'b0, 1'b0);
    check("second_det_y", {9'd0, y}, 10'd1);
    check("second_det_count", count, 10'd2);

    // 0,0,1,1,0,1,1 after a reset: never matches
    step(1'b0, 1'b1);
    foreach (hist[i]) begin end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("no_match_y", {9'd0, y}, 10'd0);
    check("no_match_count", count, 10'd0);

    // "01", reset on the would-be completing 0, then 0: partial match discarded
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("rst_priority_y", {9'd0, y}, 10'd0);
    check("rst_priority_count", count, 10'd0);
    step(1'b0, 1'b0);
    check("after_rst_y", {9'd0, y}, 10'd0);
    check("after_rst_count", count, 10'd0);

    // 1025 back-to-back non-overlapping matches from reset
    step(1'b1, 1'b1);
    for (int k = 0; k < 1025; k++) begin
      step(1'b0, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end
`ifdef SEQ_DETECT_010_SAT_EN
    check("overflow_count", count, 10'd1023);
`else
    check("overflow_count", count, 10'd1);
`endif
    check("overflow_y", {9'd0, y}, 10'd1);

    // Random stream against the model
    step(1'b0, 1'b1);
    for (int k = 0; k < 100; k++) begin
      step(1'($urandom_range(0, 1)), 1'b0);
    end
    check("random_final_count", count, count_of(nmatch));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
